// File: rtl/mux_seq.sv
// mux_seq: registered N-channel, W-bit selector with a valid/ready output stage.
// Direct mode picks the channel named by sel_i and flags out-of-range selects.
// Scan mode walks the enabled channels round-robin, starting after the last
// channel issued. Outputs are fully registered.
module mux_seq #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH*W-1:0] in_i,
    input  logic              mode_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [N_CH-1:0]   en_mask_i,
    input  logic              req_i,
    output logic [W-1:0]      out_data_o,
    output logic [SEL_W-1:0]  out_ch_o,
    output logic              out_err_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int               IW      = SEL_W + 2;
    localparam logic [IW-1:0]    NCH_I   = IW'(N_CH);
    localparam logic [SEL_W:0]   NCH_S   = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [W-1:0]     outData_q, outData_d;
    logic [SEL_W-1:0] outCh_q, outCh_d;
    logic             outErr_q, outErr_d;
    logic             outValid_q, outValid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             prevMode_q, prevMode_d;

    logic             scanRise;
    logic [SEL_W-1:0] basePtr;
    logic [IW-1:0]    startRaw, startIdx;
    logic [N_CH-1:0]  maskRot;
    logic             hitFound;
    logic [IW-1:0]    hitOffset, hitSum, hitWrap;
    logic [SEL_W-1:0] hitIdx;
    logic [W-1:0]     dirData, scanData;
    logic             selInRange;
    logic             slotFree, load;

    // Round-robin search: rotate the mask so the channel after the base pointer
    // sits at bit 0, take the lowest set bit, then map it back to a channel index.
    // A scan capture following a non-scan capture (or reset) restarts from the
    // top so the first scan beat is the lowest enabled channel.
    always_comb begin
        scanRise  = mode_i && !prevMode_q;
        basePtr   = scanRise ? LAST_CH : ptr_q;
        startRaw  = {2'b00, basePtr} + IW'(1);
        startIdx  = (startRaw >= NCH_I) ? (startRaw - NCH_I) : startRaw;
        maskRot   = N_CH'({en_mask_i, en_mask_i} >> startIdx);
        hitFound  = 1'b0;
        hitOffset = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (maskRot[i]) begin
                hitFound  = 1'b1;
                hitOffset = IW'(i);
            end
        end
        hitSum  = hitOffset + startIdx;
        hitWrap = (hitSum >= NCH_I) ? (hitSum - NCH_I) : hitSum;
        hitIdx  = hitWrap[SEL_W-1:0];
    end

    // Channel data selection for both the direct select and the scan hit.
    always_comb begin
        dirData    = '0;
        scanData   = '0;
        selInRange = ({1'b0, sel_i} < NCH_S);
        for (int c = 0; c < N_CH; c++) begin
            if (SEL_W'(c) == sel_i) begin
                dirData = in_i[c*W +: W];
            end
            if (SEL_W'(c) == hitIdx) begin
                scanData = in_i[c*W +: W];
            end
        end
    end

    // Capture / acceptance control: load a new beat when the slot is free and
    // the active mode has something to issue, otherwise hold or drain the slot.
    always_comb begin
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outErr_d   = outErr_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        prevMode_d = prevMode_q;
        slotFree   = !outValid_q || out_ready_i;
        load       = req_i && slotFree && (!mode_i || hitFound);
        if (load) begin
            outValid_d = 1'b1;
            prevMode_d = mode_i;
            if (!mode_i) begin
                outData_d = selInRange ? dirData : '0;
                outCh_d   = sel_i;
                outErr_d  = !selInRange;
            end else begin
                outData_d = scanData;
                outCh_d   = hitIdx;
                outErr_d  = 1'b0;
                ptr_d     = hitIdx;
            end
        end else if (outValid_q && out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards any pending beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b0;
            ptr_q      <= LAST_CH;
            prevMode_q <= 1'b0;
        end else begin
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outErr_q   <= outErr_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
            prevMode_q <= prevMode_d;
        end
    end

    assign out_data_o  = outData_q;
    assign out_ch_o    = outCh_q;
    assign out_err_o   = outErr_q;
    assign out_valid_o = outValid_q;

endmodule

// File: tb/tb_mux_seq.sv
// tb_mux_seq: directed bench for mux_seq with a scoreboard queue of expected beats.
// A 16-channel instance carries most of the sequence; a 12-channel instance
// exercises out-of-range direct selects.
module tb_mux_seq;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] ch;
        logic       err;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] inBus;
    logic         mode;
    logic [3:0]   sel;
    logic [15:0]  enMask;
    logic         req;
    logic         outReady;
    logic [7:0]   outData;
    logic [3:0]   outCh;
    logic         outErr;
    logic         outValid;

    logic [95:0]  inBus12;
    logic         mode12;
    logic [3:0]   sel12;
    logic [11:0]  enMask12;
    logic         req12;
    logic         ready12;
    logic [7:0]   outData12;
    logic [3:0]   outCh12;
    logic         outErr12;
    logic         outValid12;

    int checks = 0;
    int errors = 0;

    beat_t      expQ[$];
    beat_t      held;
    bit         mValid;
    logic [3:0] mPtr;
    bit         mPrevMode;
    bit         captured;

    logic [3:0] scanSeq [6] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0, 4'd5};

    mux_seq #(.N_CH(16), .W(8), .SEL_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_i(inBus), .mode_i(mode), .sel_i(sel),
        .en_mask_i(enMask), .req_i(req), .out_data_o(outData), .out_ch_o(outCh),
        .out_err_o(outErr), .out_valid_o(outValid), .out_ready_i(outReady)
    );

    mux_seq #(.N_CH(12), .W(8), .SEL_W(4)) dut12 (
        .clk_i(clk), .rst_i(rst), .in_i(inBus12), .mode_i(mode12), .sel_i(sel12),
        .en_mask_i(enMask12), .req_i(req12), .out_data_o(outData12), .out_ch_o(outCh12),
        .out_err_o(outErr12), .out_valid_o(outValid12), .out_ready_i(ready12)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setIn(input logic [7:0] base);
        for (int c = 0; c < 16; c++) begin
            inBus[c*8 +: 8] = base + 8'(c);
        end
    endtask

    // Drive one cycle of inputs, predict any capture into the scoreboard, then
    // advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic md, input logic [3:0] s,
                                 input logic [15:0] m, input logic rdy);
        int    base;
        bit    found;
        beat_t b;
        req      = r;
        mode     = md;
        sel      = s;
        enMask   = m;
        outReady = rdy;
        captured = 1'b0;
        if (r && (!mValid || rdy)) begin
            if (!md) begin
                b.data = inBus[int'(s)*8 +: 8];
                b.ch   = s;
                b.err  = 1'b0;
                expQ.push_back(b);
                captured = 1'b1;
            end else begin
                base  = mPrevMode ? int'(mPtr) : 15;
                found = 1'b0;
                for (int i = 1; i <= 16; i++) begin
                    int c;
                    c = (base + i) % 16;
                    if (!found && m[c]) begin
                        found  = 1'b1;
                        b.data = inBus[c*8 +: 8];
                        b.ch   = 4'(c);
                        b.err  = 1'b0;
                        expQ.push_back(b);
                        mPtr = 4'(c);
                    end
                end
                captured = found;
            end
            if (captured) mPrevMode = md;
        end
        if (captured) mValid = 1'b1;
        else if (mValid && rdy) mValid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Compare the output stage against the scoreboard after each cycle.
    task automatic checkOutput(input string tag);
        check({tag, "_valid"}, 32'(outValid), 32'(mValid));
        if (captured) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s_queue observed=empty expected=beat", tag);
            end else begin
                held = expQ.pop_front();
            end
        end
        if (mValid) begin
            check({tag, "_data"}, 32'(outData), 32'(held.data));
            check({tag, "_ch"},   32'(outCh),   32'(held.ch));
            check({tag, "_err"},  32'(outErr),  32'(held.err));
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 1'b0;
        mode     = 1'b0;
        sel      = '0;
        enMask   = '0;
        outReady = 1'b1;
        setIn(8'hA0);
        mode12   = 1'b0;
        sel12    = '0;
        enMask12 = '0;
        req12    = 1'b0;
        ready12  = 1'b1;
        for (int c = 0; c < 12; c++) inBus12[c*8 +: 8] = 8'h50 + 8'(c);
        mValid    = 1'b0;
        mPtr      = 4'd15;
        mPrevMode = 1'b0;
        captured  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(outValid), 32'd0);
        check("reset_data",  32'(outData),  32'd0);
        check("reset_ch",    32'(outCh),    32'd0);
        check("reset_err",   32'(outErr),   32'd0);
        check("reset_valid12", 32'(outValid12), 32'd0);
        rst = 1'b0;

        // Direct sweep, one beat per cycle.
        for (int s = 0; s < 16; s++) begin
            applyStimulus(1'b1, 1'b0, 4'(s), 16'h0000, 1'b1);
            checkOutput("sweep");
            check("sweep_lit", 32'(outData), 32'(8'hA0 + 8'(s)));
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
        checkOutput("idle");

        // Out-of-range select on the 12-channel instance.
        req12 = 1'b1;
        sel12 = 4'd13;
        @(posedge clk);
        #1;
        check("oor_valid", 32'(outValid12), 32'd1);
        check("oor_data",  32'(outData12),  32'd0);
        check("oor_ch",    32'(outCh12),    32'd13);
        check("oor_err",   32'(outErr12),   32'd1);
        sel12 = 4'd3;
        @(posedge clk);
        #1;
        check("inr_data", 32'(outData12), 32'h53);
        check("inr_ch",   32'(outCh12),   32'd3);
        check("inr_err",  32'(outErr12),  32'd0);
        req12 = 1'b0;
        @(posedge clk);
        #1;
        check("oor_drain", 32'(outValid12), 32'd0);

        // Scan with a sparse mask, then an empty mask.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1);
            checkOutput("scan");
            check("scan_seq", 32'(outCh), 32'(scanSeq[k]));
        end
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h0000, 1'b1);
        checkOutput("emptyMask");
        check("emptyMask_lit", 32'(outValid), 32'd0);

        // Backpressure while the inputs change underneath.
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1);
        checkOutput("bpStart");
        check("bpStart_ch", 32'(outCh), 32'd10);
        for (int k = 0; k < 4; k++) begin
            setIn(8'h10 * 8'(k + 1));
            applyStimulus(1'b1, 1'b1, 4'd0, 16'h8421, 1'b0);
            checkOutput("bpHold");
            check("bpHold_data", 32'(outData), 32'hAA);
        end
        setIn(8'h30);
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1);
        checkOutput("bpRelease");
        check("bpRelease_ch",   32'(outCh),   32'd15);
        check("bpRelease_data", 32'(outData), 32'h3F);
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1);
        checkOutput("bpNext");
        setIn(8'hA0);

        // Mode re-entry restarts the scan at the lowest enabled channel.
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h0080, 1'b1);
        checkOutput("reentryScan");
        check("reentry_ch7", 32'(outCh), 32'd7);
        applyStimulus(1'b1, 1'b0, 4'd2, 16'h0080, 1'b1);
        checkOutput("reentryDir");
        applyStimulus(1'b1, 1'b0, 4'd9, 16'h0080, 1'b1);
        checkOutput("reentryDir");
        applyStimulus(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1);
        checkOutput("reentryBack");
        check("reentry_ch0", 32'(outCh), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1);
        checkOutput("reentryNext");

        // Reset while a beat is stalled.
        applyStimulus(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
        checkOutput("preReset");
        rst      = 1'b1;
        req      = 1'b1;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mValid    = 1'b0;
        mPtr      = 4'd15;
        mPrevMode = 1'b0;
        expQ.delete();
        check("midReset_valid", 32'(outValid), 32'd0);
        check("midReset_data",  32'(outData),  32'd0);
        check("midReset_ch",    32'(outCh),    32'd0);
        check("midReset_err",   32'(outErr),   32'd0);
        applyStimulus(1'b1, 1'b1, 4'd0, 16'h00F0, 1'b1);
        checkOutput("postReset");
        check("postReset_ch", 32'(outCh), 32'd4);
        applyStimulus(1'b0, 1'b1, 4'd0, 16'h00F0, 1'b1);
        checkOutput("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
